mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide read/write port of the data RAM between two 32-bit word requesters: instruction fetch (IF) and data memory (DM).
- Arbitrates round-robin, then sequences each word access as four consecutive byte beats, assembling read data and splitting write data big-endian.
- Sits between the core's fetch/load-store units and the byte-wide dual-port RAM macro. It owns that RAM port exclusively.

Parameters:
- ADDR_WIDTH, 16, width of the RAM byte address. Upper requester address bits are ignored.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF word-read request; held high until if_ready is seen.
- if_addr  in  32  IF byte base address.
- if_ready  out  1  one-cycle pulse: IF read complete, if_rdata valid.
- if_rdata  out  32  assembled IF read word.
- dm_req  in  1  DM request; held high until dm_ready is seen.
- dm_we  in  1  1 = word write, 0 = word read.
- dm_addr  in  32  DM byte base address.
- dm_wdata  in  32  DM write word.
- dm_ready  out  1  one-cycle pulse: DM access complete.
- dm_rdata  out  32  assembled DM read word.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_wren  out  1  RAM write enable.
- ram_wdata  out  8  RAM write byte.
- ram_q  in  8  RAM read byte; registered RAM, valid one cycle after its address is presented.

Behaviour:
- Reset: state=IDLE, beat=0, last_grant=DM (so IF wins the first tie).
- Reset: if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, ram_addr=0, ram_wren=0, ram_wdata=0.
- RAM-side outputs come from registers only. There is no combinational path from req inputs to ram_*.
- States: IDLE, XFER, FLUSH, DONE.
- IDLE, request sampling: req inputs are sampled only in IDLE.
  - One requester high: grant it.
  - Both high: grant the one that is not last_grant.
  - On grant, at edge T: latch base = addr[ADDR_WIDTH-1:0], plus we and wdata (IF is always read). Update last_grant, set beat=0, go to XFER.
- XFER, cycles T+1..T+4, beat k = 0..3:
  - ram_addr = base + k, modulo 2^ADDR_WIDTH (0xFFFF + 1 wraps to 0x0000).
  - Write: ram_wren=1 and ram_wdata = wdata byte k, where k=0 is bits 31:24 and k=3 is bits 7:0.
  - Read: ram_wren=0. ram_q sampled at the end of cycle T+k+2 lands in rdata byte k of the granted port, same big-endian mapping.
  - After k=3: read goes to FLUSH, write goes to DONE.
- FLUSH (read only, cycle T+5): ram_wren=0, capture byte 3, go to DONE.
- DONE (read T+6, write T+5): the granted port's ready=1 for exactly this cycle, ram_wren=0, then return to IDLE.
- Latency from grant edge to ready cycle: read 6 cycles, write 5 cycles.
- Minimum occupancy: read 7 cycles, write 6 cycles, including one IDLE cycle.
- Requester contract: drop req on the edge at which ready is observed high. A req still high in the following IDLE cycle is treated as a new request.
- Port data hold rules:
  - if_rdata and dm_rdata change only while their own port's read is in progress. The other port's activity never alters them.
  - A completed value is held until the next read on that port.
  - dm_rdata is unaffected by DM writes.
- Addr, wdata or we changes while a port is granted are ignored, since the values were latched at grant.
- A non-granted request waits and is served next. Round-robin guarantees neither port waits more than one access.
- rst mid-access: at the next edge, abort with no ready pulse and ram_wren=0, and return all state and outputs to reset values. Partially written bytes remain in the RAM.

Test Plan:
- IF read, RAM[0x0010..0x0013]=0xDE,0xAD,0xBE,0xEF, if_req at edge T -> if_ready pulses in cycle T+6 only, if_rdata=0xDEADBEEF, ram_wren stays 0.
- DM write dm_addr=0x20, dm_wdata=0x11223344 -> ram_wren=1 for 4 cycles with ram_addr 0x20..0x23 and ram_wdata 0x11,0x22,0x33,0x44. dm_ready pulses at T+5. A following DM read of 0x20 returns 0x11223344.
- if_req and dm_req asserted together, both held -> IF is granted first (post-reset tie-break), DM second. Repeat the tie -> grants alternate IF, DM, IF, DM. if_rdata is unchanged during DM accesses.
- DM read at dm_addr=0x0001FFFE -> ram_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, with upper bits ignored.
- rst asserted in XFER beat 1 of a write -> next cycle ram_wren=0, all outputs 0, no dm_ready. A re-issued request completes normally.
- dm_addr and dm_wdata changed mid-access -> the RAM still sees the values latched at grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one byte-wide RAM port between two 32-bit word requesters: instruction
// fetch (IF, read only) and data memory (DM, read or write). Requests are
// arbitrated round-robin. Each granted word access runs as four byte beats on
// the RAM port. Byte 0 is the most significant byte (big-endian).
//
// Request/ready handshake: a requester raises i_*_req and holds it, together
// with its address/data, until it observes o_*_ready high for one cycle. It
// drops req on that same edge. Requests are sampled only while idle. Address,
// we and wdata are latched at grant, so later changes have no effect on the
// access in flight. A req still high in the IDLE cycle after ready starts a
// new access.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_if_req/addr     IF word-read request and byte base address
//   o_if_ready/rdata  IF completion pulse and assembled read word
//   i_dm_req/we/addr/wdata  DM request, write flag, base address, write word
//   o_dm_ready/rdata  DM completion pulse and assembled read word
//   o_ram_addr/wren/wdata   registered RAM port controls
//   i_ram_q           RAM read byte, valid one cycle after its address
//   o_dbg_state       current FSM state (IDLE=0, XFER=1, FLUSH=2, DONE=3)
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [31:0]           i_if_addr,
  output logic                  o_if_ready,
  output logic [31:0]           o_if_rdata,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [31:0]           i_dm_addr,
  input  logic [31:0]           i_dm_wdata,
  output logic                  o_dm_ready,
  output logic [31:0]           o_dm_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_wren,
  output logic [7:0]            o_ram_wdata,
  input  logic [7:0]            i_ram_q,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [1:0]            r_beat;
  logic                  r_last_dm;   // 1 = DM was granted last
  logic                  r_sel_dm;    // port owning the current access
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic                  r_if_ready;
  logic                  r_dm_ready;
  logic [31:0]           r_if_rdata;
  logic [31:0]           r_dm_rdata;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_ram_wren;
  logic [7:0]            r_ram_wdata;

  // Big-endian byte lane select: k=0 is bits 31:24.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  // Tie goes to whichever port was not granted last.
  logic                  w_grant_any;
  logic                  w_grant_dm;
  logic                  w_grant_we;
  logic [ADDR_WIDTH-1:0] w_grant_base;
  logic [1:0]            w_next_beat;
  logic [1:0]            w_prev_beat;
  logic                  w_unused;

  assign w_grant_any  = i_if_req | i_dm_req;
  assign w_grant_dm   = i_dm_req & (~i_if_req | ~r_last_dm);
  assign w_grant_we   = w_grant_dm & i_dm_we;
  assign w_grant_base = w_grant_dm ? i_dm_addr[ADDR_WIDTH-1:0] : i_if_addr[ADDR_WIDTH-1:0];
  assign w_next_beat  = r_beat + 2'd1;
  // The RAM is registered: the byte addressed in beat k arrives during beat k+1.
  assign w_prev_beat  = r_beat - 2'd1;
  assign w_unused     = ^{i_if_addr[31:ADDR_WIDTH], i_dm_addr[31:ADDR_WIDTH]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_beat      <= 2'd0;
      r_last_dm   <= 1'b1;
      r_sel_dm    <= 1'b0;
      r_we        <= 1'b0;
      r_base      <= '0;
      r_wdata     <= 32'd0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_dm_rdata  <= 32'd0;
      r_ram_addr  <= '0;
      r_ram_wren  <= 1'b0;
      r_ram_wdata <= 8'd0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_sel_dm    <= w_grant_dm;
            r_last_dm   <= w_grant_dm;
            r_we        <= w_grant_we;
            r_base      <= w_grant_base;
            r_wdata     <= i_dm_wdata;
            r_beat      <= 2'd0;
            r_ram_addr  <= w_grant_base;
            r_ram_wren  <= w_grant_we;
            r_ram_wdata <= w_grant_we ? i_dm_wdata[31:24] : 8'd0;
            r_state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (!r_we && r_beat != 2'd0) begin
            if (r_sel_dm) r_dm_rdata <= put_byte(r_dm_rdata, w_prev_beat, i_ram_q);
            else          r_if_rdata <= put_byte(r_if_rdata, w_prev_beat, i_ram_q);
          end
          if (r_beat == 2'd3) begin
            r_ram_wren <= 1'b0;
            if (r_we) begin
              r_dm_ready <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_state    <= S_FLUSH;
            end
          end else begin
            r_beat      <= w_next_beat;
            r_ram_addr  <= r_base + {{(ADDR_WIDTH-2){1'b0}}, w_next_beat};
            r_ram_wdata <= r_we ? get_byte(r_wdata, w_next_beat) : 8'd0;
          end
        end
        S_FLUSH: begin
          // Last read byte arrives one cycle after the final address beat.
          if (r_sel_dm) begin
            r_dm_rdata <= put_byte(r_dm_rdata, 2'd3, i_ram_q);
            r_dm_ready <= 1'b1;
          end else begin
            r_if_rdata <= put_byte(r_if_rdata, 2'd3, i_ram_q);
            r_if_ready <= 1'b1;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_if_ready  = r_if_ready;
  assign o_dm_ready  = r_dm_ready;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wren  = r_ram_wren;
  assign o_ram_wdata = r_ram_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: byte RAM model, reset checks, a vector table,
// hand-written tie/reset/scramble sequences and a randomized phase checked
// against a word-level shadow-memory model.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          scramble;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ready, dm_ready;
  logic [31:0] if_rdata, dm_rdata;
  logic [15:0] ram_addr;
  logic        ram_wren;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_q;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_ready  (if_ready),
    .o_if_rdata  (if_rdata),
    .i_dm_req    (dm_req),
    .i_dm_we     (dm_we),
    .i_dm_addr   (dm_addr),
    .i_dm_wdata  (dm_wdata),
    .o_dm_ready  (dm_ready),
    .o_dm_rdata  (dm_rdata),
    .o_ram_addr  (ram_addr),
    .o_ram_wren  (ram_wren),
    .o_ram_wdata (ram_wdata),
    .i_ram_q     (ram_q),
    .o_dbg_state (dbg_state)
  );

  // ---------------- RAM model (registered read) ----------------
  logic [7:0] ram_mem [0:65535];
  always @(posedge clk) begin
    ram_q <= ram_mem[ram_addr];
    if (ram_wren) ram_mem[ram_addr] = ram_wdata;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  shadow [0:65535];
  bit          model_last_dm;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    logic [31:0] w;
    logic [15:0] a;
    w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      a = addr[15:0] + 16'(i);
      w = (w << 8) | {24'd0, shadow[a]};
    end
    return w;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = addr[15:0] + 16'(i);
      shadow[a] = 8'((wdata >> (8 * (3 - i))) & 32'hFF);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_single(input bit is_dm, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd,
                            input bit scramble);
    int          lat;
    logic [15:0] base;
    lat  = we ? 5 : 6;
    base = addr[15:0];
    @(negedge clk);
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (j <= 4) begin
        check("ram_addr", {16'd0, ram_addr}, {16'd0, base + 16'(j - 1)});
        check("ram_wren", {31'd0, ram_wren}, {31'd0, we});
        if (we) check("ram_wdata", {24'd0, ram_wdata}, (wdata >> (8 * (4 - j))) & 32'hFF);
      end else begin
        check("ram_wren_tail", {31'd0, ram_wren}, 32'd0);
      end
      if (is_dm) begin
        check("dm_ready", {31'd0, dm_ready}, {31'd0, j == lat});
        check("if_ready_idle", {31'd0, if_ready}, 32'd0);
        check("if_rdata_hold", if_rdata, exp_if_rdata);
        if (we) check("dm_rdata_hold", dm_rdata, exp_dm_rdata);
      end else begin
        check("if_ready", {31'd0, if_ready}, {31'd0, j == lat});
        check("dm_ready_idle", {31'd0, dm_ready}, 32'd0);
        check("dm_rdata_hold", dm_rdata, exp_dm_rdata);
      end
      if (j == lat) begin
        if (!we) begin
          if (is_dm) begin
            check("dm_rdata", dm_rdata, exp_rd);
            exp_dm_rdata = exp_rd;
          end else begin
            check("if_rdata", if_rdata, exp_rd);
            exp_if_rdata = exp_rd;
          end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
      end else if (scramble) begin
        if_addr  = $urandom;
        dm_addr  = $urandom;
        dm_wdata = $urandom;
        dm_we    = 1'($urandom_range(0, 1));
      end
    end
    if (is_dm && we) model_write(addr, wdata);
    model_last_dm = is_dm;
  endtask

  // Both ports request together; the port not served last must go first.
  task automatic run_pair(input logic [31:0] i_addr, input bit d_we,
                          input logic [31:0] d_addr, input logic [31:0] d_wdata);
    bit          if_first, if_done, dm_done;
    int          lat_dm, t_if, t_dm;
    logic [31:0] e_if, e_dm;
    lat_dm   = d_we ? 5 : 6;
    if_first = model_last_dm;
    e_dm     = 32'd0;
    if (if_first) begin
      e_if = model_word(i_addr);
      if (d_we) model_write(d_addr, d_wdata); else e_dm = model_word(d_addr);
      t_if = 6;
      t_dm = 6 + 1 + lat_dm;
    end else begin
      if (d_we) model_write(d_addr, d_wdata); else e_dm = model_word(d_addr);
      e_if = model_word(i_addr);
      t_dm = lat_dm;
      t_if = lat_dm + 1 + 6;
    end
    model_last_dm = if_first;
    exp_q.push_back(e_if);
    exp_q.push_back(d_we ? exp_dm_rdata : e_dm);
    @(negedge clk);
    if_req = 1'b1; if_addr = i_addr;
    dm_req = 1'b1; dm_we = d_we; dm_addr = d_addr; dm_wdata = d_wdata;
    if_done = 1'b0;
    dm_done = 1'b0;
    for (int j = 1; j <= 40 && !(if_done && dm_done); j++) begin
      @(negedge clk);
      if (if_ready) begin
        check("pair_if_cycle", j, t_if);
        check("pair_if_rdata", if_rdata, exp_q[0]);
        exp_if_rdata = exp_q[0];
        if_req  = 1'b0;
        if_done = 1'b1;
      end
      if (dm_ready) begin
        check("pair_dm_cycle", j, t_dm);
        check("pair_dm_rdata", dm_rdata, exp_q[1]);
        exp_dm_rdata = exp_q[1];
        dm_req  = 1'b0;
        dm_done = 1'b1;
      end
    end
    check("pair_if_done", {31'd0, if_done}, 32'd1);
    check("pair_dm_done", {31'd0, dm_done}, 32'd1);
    check("pair_if_hold", if_rdata, exp_if_rdata);
    check("pair_dm_hold", dm_rdata, exp_dm_rdata);
    if_req = 1'b0;
    dm_req = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_ready"},  {31'd0, if_ready}, 32'd0);
    check({tag, "_dm_ready"},  {31'd0, dm_ready}, 32'd0);
    check({tag, "_if_rdata"},  if_rdata, 32'd0);
    check({tag, "_dm_rdata"},  dm_rdata, 32'd0);
    check({tag, "_ram_addr"},  {16'd0, ram_addr}, 32'd0);
    check({tag, "_ram_wren"},  {31'd0, ram_wren}, 32'd0);
    check({tag, "_ram_wdata"}, {24'd0, ram_wdata}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs [9];

  initial begin
    bit          r_dm, r_we, r_scr;
    int          kind;
    logic [31:0] ra, rb, rw;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h11223344,  32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h11223344, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0001_FFFE, 32'hCAFEF00D,  32'h0,        1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0001_FFFE, 32'h0,         32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'hABCD_0000, 32'h0,         32'hF00D0000, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0030, 32'h55667788,  32'h0,        1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0030, 32'h0,         32'h55667788, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         32'hBEEF0000, 1'b0};

    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'd0;
      shadow[i]  = 8'd0;
    end
    ram_mem[16'h0010] = 8'hDE; ram_mem[16'h0011] = 8'hAD;
    ram_mem[16'h0012] = 8'hBE; ram_mem[16'h0013] = 8'hEF;
    shadow[16'h0010]  = 8'hDE; shadow[16'h0011]  = 8'hAD;
    shadow[16'h0012]  = 8'hBE; shadow[16'h0013]  = 8'hEF;

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
    model_last_dm = 1'b1;
    exp_if_rdata  = 32'd0;
    exp_dm_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Tie-break after reset favours IF, then alternates.
    run_pair(32'h0000_0010, 1'b1, 32'h0000_0050, 32'h01020304);
    run_pair(32'h0000_0050, 1'b0, 32'h0000_0010, 32'h0);

    for (int i = 0; i < 9; i++)
      run_single(vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].scramble);

    // Reset during beat 1 of a DM write.
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0040; dm_wdata = 32'hAABBCCDD;
    @(negedge clk);
    @(negedge clk);
    check("abort_beat1_addr", {16'd0, ram_addr}, 32'h0000_0041);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    dm_req = 1'b0;
    shadow[16'h0040] = 8'hAA;
    shadow[16'h0041] = 8'hBB;
    model_last_dm = 1'b1;
    exp_if_rdata  = 32'd0;
    exp_dm_rdata  = 32'd0;
    run_single(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hAABB0000, 1'b0);
    run_single(1'b1, 1'b1, 32'h0000_0040, 32'hAABBCCDD, 32'h0, 1'b0);
    run_single(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hAABBCCDD, 1'b0);

    // Randomized traffic checked against the shadow-memory model.
    for (int n = 0; n < 120; n++) begin
      kind  = $urandom_range(0, 2);
      ra    = {16'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                           : 16'($urandom_range(0, 63))};
      rb    = {16'($urandom), 16'($urandom_range(0, 63))};
      rw    = $urandom;
      r_we  = 1'($urandom_range(0, 1));
      r_scr = 1'($urandom_range(0, 1));
      if (kind == 2) begin
        run_pair(ra, r_we, rb, rw);
      end else begin
        r_dm = (kind == 1);
        if (!r_dm) r_we = 1'b0;
        run_single(r_dm, r_we, ra, rw, r_we ? 32'h0 : model_word(ra), r_scr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
